// File: rtl/tv_sequencer_pkg.sv
// Shared types for the test-vector sequencer: FSM states, the stored vector
// layout and a saturating counter helper.
package tv_sequencer_pkg;

  localparam int VEC_IN_W  = 8;
  localparam int VEC_OUT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } state_e;

  // One stored vector: stimulus, golden response and check mask (1 = checked)
  typedef struct packed {
    logic [VEC_IN_W-1:0]  stim;
    logic [VEC_OUT_W-1:0] golden;
    logic [VEC_OUT_W-1:0] mask;
  } vec_t;

  // Increment that sticks at 255 so a long failing run never wraps to "clean"
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tv_sequencer_if.sv
// Request/response handshake between the sequencer (master) and the DUT
// under test (slave). At most one request is outstanding at a time.
interface tv_sequencer_if
  import tv_sequencer_pkg::*;
#(
  parameter int IN_W  = VEC_IN_W,
  parameter int OUT_W = VEC_OUT_W
) ();

  logic             req_val;
  logic             req_rdy;
  logic [IN_W-1:0]  req_msg;
  logic             resp_val;
  logic             resp_rdy;
  logic [OUT_W-1:0] resp_msg;

  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );

endinterface

// File: rtl/tv_sequencer_mem.sv
// Vector storage: DEPTH-entry register file with one synchronous write port
// and one combinational read port. Contents survive reset on purpose so a
// run can be repeated after a reset without reloading.
module tv_sequencer_mem
  import tv_sequencer_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = vec_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem_q [DEPTH];

  // Store a vector when the write port is enabled
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tv_sequencer.sv
// Test-vector sequencer: plays stored vectors into a DUT one at a time,
// compares masked responses, counts mismatches and guards each response
// with a cycle watchdog.
module tv_sequencer
  import tv_sequencer_pkg::*;
#(
  parameter int  IN_W    = VEC_IN_W,
  parameter int  OUT_W   = VEC_OUT_W,
  parameter int  DEPTH   = 16,
  parameter int  TIMEOUT = 64,
  localparam int AW      = $clog2(DEPTH),
  localparam int NW      = AW + 1,
  localparam int TW      = $clog2(TIMEOUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NW-1:0]        num_vec,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [IN_W-1:0]      cfg_in,
  input  logic [OUT_W-1:0]     cfg_ref,
  input  logic [OUT_W-1:0]     cfg_mask,
  tv_sequencer_if.master       dut_if,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic [AW-1:0]        fail_idx,
  output logic                 timeout
);

  typedef struct packed {
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] golden;
    logic [OUT_W-1:0] mask;
  } entry_t;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [NW-1:0] num_q, num_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    err_q, err_d;
  logic [AW-1:0] fail_q, fail_d;
  logic          timeout_q, timeout_d;
  logic          pass_q, pass_d;

  entry_t        wr_entry, rd_entry;
  logic          mismatch;
  logic          last_vec;
  logic [7:0]    err_inc;

  assign wr_entry = '{stim: cfg_in, golden: cfg_ref, mask: cfg_mask};

  tv_sequencer_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk   (clk),
    .we    (cfg_we & ~busy),
    .waddr (cfg_addr),
    .wdata (wr_entry),
    .raddr (idx_q),
    .rdata (rd_entry)
  );

  assign mismatch = |((dut_if.resp_msg ^ rd_entry.golden) & rd_entry.mask);
  assign last_vec = ({1'b0, idx_q} == (num_q - NW'(1)));

  // State and run bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      timer_q   <= '0;
      err_q     <= '0;
      fail_q    <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
    end
  end

  // Next-state: run start, request handshake, response check and watchdog
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    timer_d   = timer_q;
    err_d     = err_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    err_inc   = mismatch ? sat_inc8(err_q) : err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          err_d     = '0;
          fail_d    = '0;
          timeout_d = 1'b0;
          idx_d     = '0;
          pass_d    = 1'b0;
          num_d     = (num_vec > NW'(DEPTH)) ? NW'(DEPTH) : num_vec;
          if (num_vec == '0) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (dut_if.req_rdy) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        if (dut_if.resp_val) begin
          err_d = err_inc;
          if (mismatch && (err_q == 8'd0)) fail_d = idx_q;
          if (last_vec) begin
            state_d = DONE;
            pass_d  = (err_inc == 8'd0) && !timeout_q;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SEND;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    dut_if.req_val  = 1'b0;
    dut_if.resp_rdy = 1'b0;
    dut_if.req_msg  = '0;
    case (state_q)
      SEND: begin
        busy           = 1'b1;
        dut_if.req_val = 1'b1;
        dut_if.req_msg = rd_entry.stim;
      end
      WAIT: begin
        busy            = 1'b1;
        dut_if.resp_rdy = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_idx  = fail_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_tv_sequencer.sv
// Scoreboard bench for tv_sequencer: directed runs push expected requests and
// run summaries into queues; a monitor pops and compares them as the DUT
// issues requests and finishes runs. A small behavioural DUT sits on the
// slave side of the handshake interface.
module tb_tv_sequencer;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int AW      = 4;
  localparam int NW      = 5;

  typedef struct packed {
    logic       p;
    logic [7:0] err;
    logic [3:0] fidx;
    logic       to;
  } summary_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NW-1:0] num_vec = '0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [7:0]    cfg_in = '0;
  logic [7:0]    cfg_ref = '0;
  logic [7:0]    cfg_mask = '0;
  logic          busy, done, pass, timeout;
  logic [7:0]    err_count;
  logic [AW-1:0] fail_idx;

  int            checks = 0;
  int            errors = 0;
  int unsigned   cyc = 0;
  int unsigned   last_req_cyc = 0;
  int unsigned   done_cyc = 0;
  int            slave_mode = 0;
  int            stall_cnt = 0;
  logic          mon_done_prev = 1'b0;
  logic          mon_start_prev = 1'b0;

  logic [7:0]    model_in [DEPTH];
  logic [7:0]    exp_req_q [$];
  summary_t      exp_sum_q [$];

  tv_sequencer_if #(.IN_W(8), .OUT_W(8)) dut_if ();

  tv_sequencer #(
    .IN_W    (8),
    .OUT_W   (8),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_vec   (num_vec),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_in    (cfg_in),
    .cfg_ref   (cfg_ref),
    .cfg_mask  (cfg_mask),
    .dut_if    (dut_if),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_idx  (fail_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadVector(input int addr, input logic [7:0] vin,
                            input logic [7:0] vref, input logic [7:0] vmask,
                            input bit track);
    @(posedge clk); #1;
    cfg_we   = 1'b1;
    cfg_addr = addr[AW-1:0];
    cfg_in   = vin;
    cfg_ref  = vref;
    cfg_mask = vmask;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (track) model_in[addr] = vin;
  endtask

  task automatic applyStimulus(input int nv, input int nreq, input logic ep,
                               input logic [7:0] ee, input logic [3:0] ef,
                               input logic et, output int waited);
    summary_t s;
    for (int i = 0; i < nreq; i++) exp_req_q.push_back(model_in[i]);
    s.p = ep; s.err = ee; s.fidx = ef; s.to = et;
    exp_sum_q.push_back(s);
    @(posedge clk); #1;
    num_vec = nv[NW-1:0];
    start   = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!done && waited < 2000);
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_done: done=%0b after %0d cycles, required 1", done, waited);
    end
    repeat (2) @(negedge clk);
  endtask

  // Behavioural DUT: loopback with a one-cycle response, optional silence
  // and optional request stall
  initial begin : slave_model
    logic       req_hs;
    logic       resp_hs;
    logic [7:0] req_cap;
    dut_if.req_rdy  = 1'b1;
    dut_if.resp_val = 1'b0;
    dut_if.resp_msg = '0;
    forever begin
      @(negedge clk);
      req_hs  = dut_if.req_val & dut_if.req_rdy;
      req_cap = dut_if.req_msg;
      resp_hs = dut_if.resp_val & dut_if.resp_rdy;
      @(posedge clk); #1;
      if (resp_hs || reset) dut_if.resp_val = 1'b0;
      if (req_hs && slave_mode == 0 && !reset) begin
        dut_if.resp_val = 1'b1;
        dut_if.resp_msg = req_cap;
      end
      if (stall_cnt > 0) stall_cnt--;
      dut_if.req_rdy = (stall_cnt == 0);
    end
  end

  // Monitor: compare every request handshake and every run completion
  initial begin : monitor
    logic [7:0] exp_msg;
    summary_t   s;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_done_prev  = 1'b0;
        mon_start_prev = 1'b0;
      end else begin
        if (dut_if.req_val && dut_if.req_rdy) begin
          last_req_cyc = cyc;
          if (exp_req_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_unexpected: got req_msg 0x%0h, required no request", dut_if.req_msg);
          end else begin
            exp_msg = exp_req_q.pop_front();
            checkOutput("req_msg", {24'd0, dut_if.req_msg}, {24'd0, exp_msg});
          end
        end
        if (done && (!mon_done_prev || mon_start_prev)) begin
          done_cyc = cyc;
          if (exp_sum_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_unexpected: got done=1, required no run end");
          end else begin
            s = exp_sum_q.pop_front();
            checkOutput("pass",      {31'd0, pass},      {31'd0, s.p});
            checkOutput("err_count", {24'd0, err_count}, {24'd0, s.err});
            checkOutput("fail_idx",  {28'd0, fail_idx},  {28'd0, s.fidx});
            checkOutput("timeout",   {31'd0, timeout},   {31'd0, s.to});
            checkOutput("busy_at_done",     {31'd0, busy},            32'd0);
            checkOutput("resp_rdy_at_done", {31'd0, dut_if.resp_rdy}, 32'd0);
          end
        end
        mon_done_prev  = done;
        mon_start_prev = start;
      end
    end
  end

  // Directed test sequence
  initial begin : stimulus
    int waited;
    int cnt;
    int guard;

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_val",   {31'd0, dut_if.req_val},  32'd0);
    checkOutput("rst_resp_rdy",  {31'd0, dut_if.resp_rdy}, 32'd0);
    checkOutput("rst_req_msg",   {24'd0, dut_if.req_msg},  32'd0);
    checkOutput("rst_busy",      {31'd0, busy},            32'd0);
    checkOutput("rst_done",      {31'd0, done},            32'd0);
    checkOutput("rst_pass",      {31'd0, pass},            32'd0);
    checkOutput("rst_err_count", {24'd0, err_count},       32'd0);
    checkOutput("rst_fail_idx",  {28'd0, fail_idx},        32'd0);
    checkOutput("rst_timeout",   {31'd0, timeout},         32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      loadVector(i, 8'(i + 1), 8'(i + 1), 8'hFF, 1'b1);

    $display("[TB] clean loopback run");
    applyStimulus(4, 4, 1'b1, 8'd0, 4'd0, 1'b0, waited);

    $display("[TB] single mismatch on vector 2");
    loadVector(2, 8'h03, 8'h07, 8'hFF, 1'b1);
    applyStimulus(4, 4, 1'b0, 8'd1, 4'd2, 1'b0, waited);

    $display("[TB] mismatch bit masked off");
    loadVector(2, 8'h03, 8'h07, 8'hF8, 1'b1);
    applyStimulus(4, 4, 1'b1, 8'd0, 4'd0, 1'b0, waited);

    $display("[TB] two mismatches, first at vector 1");
    loadVector(1, 8'h02, 8'h12, 8'hFF, 1'b1);
    loadVector(3, 8'h04, 8'h00, 8'h0F, 1'b1);
    applyStimulus(4, 4, 1'b0, 8'd2, 4'd1, 1'b0, waited);
    loadVector(1, 8'h02, 8'h02, 8'hFF, 1'b1);
    loadVector(2, 8'h03, 8'h03, 8'hFF, 1'b1);
    loadVector(3, 8'h04, 8'h04, 8'hFF, 1'b1);

    $display("[TB] num_vec above DEPTH clamps to DEPTH");
    applyStimulus(20, 16, 1'b1, 8'd0, 4'd0, 1'b0, waited);

    $display("[TB] silent DUT triggers watchdog");
    slave_mode = 1;
    applyStimulus(4, 1, 1'b0, 8'd0, 4'd0, 1'b1, waited);
    checkOutput("timeout_latency", done_cyc - last_req_cyc, TIMEOUT + 1);
    checkOutput("resp_rdy_after_timeout", {31'd0, dut_if.resp_rdy}, 32'd0);
    slave_mode = 0;

    $display("[TB] long request stall is not a timeout");
    @(negedge clk);
    stall_cnt      = 100;
    dut_if.req_rdy = 1'b0;
    applyStimulus(4, 4, 1'b1, 8'd0, 4'd0, 1'b0, waited);
    checkOutput("stall_duration", {31'd0, (waited >= 100)}, 32'd1);

    $display("[TB] zero-length run");
    applyStimulus(0, 0, 1'b1, 8'd0, 4'd0, 1'b0, waited);
    checkOutput("zero_run_latency", waited, 32'd1);

    $display("[TB] config write while busy is ignored");
    fork
      applyStimulus(4, 4, 1'b1, 8'd0, 4'd0, 1'b0, waited);
      begin
        repeat (3) @(posedge clk);
        loadVector(0, 8'hAA, 8'h55, 8'hFF, 1'b0);
      end
    join
    applyStimulus(4, 4, 1'b1, 8'd0, 4'd0, 1'b0, waited);

    $display("[TB] reset during WAIT of vector 1");
    exp_req_q.push_back(model_in[0]);
    exp_req_q.push_back(model_in[1]);
    @(posedge clk); #1;
    num_vec = 5'd4;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt   = 0;
    guard = 0;
    while (cnt < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (dut_if.resp_rdy) cnt++;
    end
    checkOutput("reach_wait_vec1", cnt, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_req_val",   {31'd0, dut_if.req_val},  32'd0);
    checkOutput("mid_rst_resp_rdy",  {31'd0, dut_if.resp_rdy}, 32'd0);
    checkOutput("mid_rst_busy",      {31'd0, busy},            32'd0);
    checkOutput("mid_rst_done",      {31'd0, done},            32'd0);
    checkOutput("mid_rst_err_count", {24'd0, err_count},       32'd0);
    checkOutput("mid_rst_fail_idx",  {28'd0, fail_idx},        32'd0);
    checkOutput("mid_rst_timeout",   {31'd0, timeout},         32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(4, 4, 1'b1, 8'd0, 4'd0, 1'b0, waited);

    checkOutput("req_queue_drained", exp_req_q.size(), 32'd0);
    checkOutput("sum_queue_drained", exp_sum_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so a stuck run can never hang the simulation
  initial begin : time_limit
    #500000;
    $display("[TB] FAIL time_limit: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] time limit exceeded");
  end

endmodule
